// File: rtl/ola_pwm_pkg.sv
// Shared constants and arithmetic helpers for the overlap-add PWM output stage.
//   AXIS_W    : width of one source lane in the packed AXI-Stream tdata bus
//   SAT_W     : working width for the generic saturate / duty helpers
//   sat_s     : clamp a signed value to a signed range of 'width' bits
//   to_offset : convert a signed sample to an offset-binary PWM duty word
package ola_pwm_pkg;

    localparam int unsigned AXIS_W = 32;
    localparam int unsigned SAT_W  = 48;

    // Clamp val into [-2**(width-1), 2**(width-1)-1]; result stays SAT_W wide.
    function automatic logic signed [SAT_W-1:0] sat_s(
        input logic signed [SAT_W-1:0] val,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (width - 1)) - SAT_W'(1));
        lo = ~hi;
        if (val > hi) begin
            return hi;
        end
        if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

    // Top pwm_w bits of a data_w-bit signed sample with the sign bit inverted.
    function automatic logic [15:0] to_offset(
        input logic [SAT_W-1:0] sample,
        input int unsigned      data_w,
        input int unsigned      pwm_w
    );
        logic [SAT_W-1:0] top;
        top = (sample >> (data_w - pwm_w)) & ((SAT_W'(1) << pwm_w) - SAT_W'(1));
        top = top ^ (SAT_W'(1) << (pwm_w - 1));
        return top[15:0];
    endfunction

endpackage

// File: rtl/ola_pwm_out_pwm_modulator.sv
// PWM timebase and modulator.
//   clk, rst     : clock, synchronous active-high reset
//   duty_in      : next duty word, captured at the first period wrap after a request
//   duty_ld_req  : one-cycle request to load duty_in at the next period boundary
//   mute         : when set at the load point, mid-scale duty is loaded instead
//   tick         : one cycle per audio sample (last clock of the last PWM period)
//   AUD_PWM      : registered PWM output, high while pwm_cnt < duty
module pwm_modulator #(
    parameter int unsigned PWM_W      = 8,
    parameter int unsigned PERIODS_PS = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] duty_in,
    input  logic             duty_ld_req,
    input  logic             mute,
    output logic             tick,
    output logic             AUD_PWM
);

    localparam int unsigned      PER_W    = $clog2(PERIODS_PS + 1);
    localparam logic [PWM_W-1:0] DUTY_MID = {1'b1, {(PWM_W-1){1'b0}}};
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIODS_PS - 1);

    logic [PWM_W-1:0] pwm_cnt;
    logic [PER_W-1:0] per_cnt;
    logic [PWM_W-1:0] duty;
    logic             ld_pend;
    logic             wrap;

    assign wrap = &pwm_cnt;
    assign tick = wrap && (per_cnt == PER_LAST);

    // Counters, duty register (only updated on a wrap, so no mid-period glitches) and output.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            per_cnt <= '0;
            duty    <= DUTY_MID;
            ld_pend <= 1'b0;
            AUD_PWM <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (wrap) begin
                per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + PER_W'(1);
            end
            if (wrap && (ld_pend || duty_ld_req)) begin
                duty    <= mute ? DUTY_MID : duty_in;
                ld_pend <= 1'b0;
            end else if (duty_ld_req) begin
                ld_pend <= 1'b1;
            end
            AUD_PWM <= (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/ola_pwm_out.sv
// Overlap-add audio output stage: joins NUM_SRC staggered iFFT streams once per audio
// tick, sums with gain shift and saturation, and drives a PWM DAC plus amp enable.
//   clk, rst       : clock, synchronous active-high reset
//   s_axis_*       : NUM_SRC packed AXI-Stream sources, consumed together at the tick
//   gain_shift     : arithmetic right shift of the sum (0..15)
//   mute           : forces mid-scale duty; samples are still consumed
//   AUD_PWM/AUD_SD : PWM audio output / amplifier enable
//   sample_out     : last accepted overlapped sample, with sample_strobe pulse
//   underrun_cnt   : saturating count of ticks with a missing source
//   misalign       : sticky flag, tlast disagreed across sources at a handshake
module ola_pwm_out #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned PWM_W      = 8,
    parameter int unsigned PERIODS_PS = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC*32-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]    s_axis_tvalid,
    input  logic [NUM_SRC-1:0]    s_axis_tlast,
    output logic [NUM_SRC-1:0]    s_axis_tready,
    input  logic [3:0]            gain_shift,
    input  logic                  mute,
    output logic                  AUD_PWM,
    output logic                  AUD_SD,
    output logic [DATA_W-1:0]     sample_out,
    output logic                  sample_strobe,
    output logic [15:0]           underrun_cnt,
    output logic                  misalign
);

    import ola_pwm_pkg::*;

    localparam int unsigned SUM_W = DATA_W + $clog2(NUM_SRC) + 1;

    logic                    tick;
    logic                    all_v;
    logic                    accept;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] scaled;
    logic signed [SAT_W-1:0] sat_wide;
    logic [DATA_W-1:0]       sat_val;
    logic [PWM_W-1:0]        duty_next;
    logic                    unused_bits;

    // All sources move together, and only on the tick; rst gates a stray handshake.
    assign all_v         = &s_axis_tvalid;
    assign accept        = tick & all_v & ~rst;
    assign s_axis_tready = {NUM_SRC{accept}};

    // Sign-extended sum of the real parts of every lane.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sum = sum + SUM_W'($signed(s_axis_tdata[k*AXIS_W +: DATA_W]));
        end
    end

    assign scaled    = sum >>> gain_shift;
    assign sat_wide  = sat_s(SAT_W'(scaled), DATA_W);
    assign sat_val   = DATA_W'(sat_wide);
    assign duty_next = PWM_W'(to_offset(SAT_W'(sample_out), DATA_W, PWM_W));

    // Imaginary halves of the lanes and the clamped-away high bits are intentionally dropped.
    always_comb begin
        unused_bits = ^sat_wide[SAT_W-1:DATA_W];
        for (int k = 0; k < NUM_SRC; k++) begin
            unused_bits = unused_bits ^ (^s_axis_tdata[k*AXIS_W + DATA_W +: AXIS_W - DATA_W]);
        end
    end

    // Sample capture and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out    <= '0;
            sample_strobe <= 1'b0;
            underrun_cnt  <= '0;
            misalign      <= 1'b0;
            AUD_SD        <= 1'b0;
        end else begin
            AUD_SD        <= 1'b1;
            sample_strobe <= accept;
            if (accept) begin
                sample_out <= sat_val;
                if ((|s_axis_tlast) && !(&s_axis_tlast)) begin
                    misalign <= 1'b1;
                end
            end
            if (tick && !all_v && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

    pwm_modulator #(
        .PWM_W      (PWM_W),
        .PERIODS_PS (PERIODS_PS)
    ) u_mod (
        .clk         (clk),
        .rst         (rst),
        .duty_in     (duty_next),
        .duty_ld_req (sample_strobe),
        .mute        (mute),
        .tick        (tick),
        .AUD_PWM     (AUD_PWM)
    );

endmodule

// File: tb/tb_ola_pwm_out.sv
// Directed bench for ola_pwm_out with NUM_SRC=2, DATA_W=16, PWM_W=8, PERIODS_PS=9.
module tb_ola_pwm_out;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_axis_tdata;
    logic [1:0]  s_axis_tvalid;
    logic [1:0]  s_axis_tlast;
    logic [1:0]  s_axis_tready;
    logic [3:0]  gain_shift;
    logic        mute;
    logic        AUD_PWM;
    logic        AUD_SD;
    logic [15:0] sample_out;
    logic        sample_strobe;
    logic [15:0] underrun_cnt;
    logic        misalign;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ola_pwm_out #(
        .NUM_SRC    (2),
        .DATA_W     (16),
        .PWM_W      (8),
        .PERIODS_PS (9)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .gain_shift    (gain_shift),
        .mute          (mute),
        .AUD_PWM       (AUD_PWM),
        .AUD_SD        (AUD_SD),
        .sample_out    (sample_out),
        .sample_strobe (sample_strobe),
        .underrun_cnt  (underrun_cnt),
        .misalign      (misalign)
    );

    typedef struct {
        logic signed [15:0] s0;
        logic signed [15:0] s1;
        logic [3:0]         sh;
        logic               mu;
        logic signed [15:0] exp_s;
        int                 exp_duty;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Upper halves carry junk to confirm only the real part is used.
    task automatic set_src(input logic signed [15:0] s0, input logic signed [15:0] s1,
                           input logic [3:0] sh, input logic mu);
        s_axis_tdata = {16'hA5A5, s1, 16'h5A5A, s0};
        gain_shift   = sh;
        mute         = mu;
    endtask

    task automatic wait_tick(output int at);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (s_axis_tready != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        at = cyc;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: no handshake within 3000 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic count_high(output int highs);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (AUD_PWM) highs++;
        end
    endtask

    initial begin
        int t_prev;
        int t_now;
        int rel_cyc;
        int highs;
        bit saw_ready;
        bit saw_strobe;
        logic [15:0] prev_ur;

        vecs[0] = '{s0: 16'sd100,    s1: -16'sd40,    sh: 4'd0,  mu: 1'b0, exp_s: 16'sd60,     exp_duty: 128};
        vecs[1] = '{s0: 16'sd32767,  s1: 16'sd32767,  sh: 4'd0,  mu: 1'b0, exp_s: 16'sd32767,  exp_duty: 255};
        vecs[2] = '{s0: 16'sd32767,  s1: 16'sd32767,  sh: 4'd1,  mu: 1'b0, exp_s: 16'sd32767,  exp_duty: 255};
        vecs[3] = '{s0: -16'sd101,   s1: -16'sd40,    sh: 4'd2,  mu: 1'b0, exp_s: -16'sd36,    exp_duty: 127};
        vecs[4] = '{s0: 16'sd20000,  s1: 16'sd10000,  sh: 4'd0,  mu: 1'b0, exp_s: 16'sd30000,  exp_duty: 245};
        vecs[5] = '{s0: -16'sd30000, s1: -16'sd10000, sh: 4'd0,  mu: 1'b0, exp_s: -16'sd32768, exp_duty: 0};
        vecs[6] = '{s0: 16'sd20000,  s1: 16'sd0,      sh: 4'd0,  mu: 1'b1, exp_s: 16'sd20000,  exp_duty: 128};
        vecs[7] = '{s0: 16'sd100,    s1: -16'sd40,    sh: 4'd15, mu: 1'b0, exp_s: 16'sd0,      exp_duty: 128};

        // Reset state
        s_axis_tvalid = 2'b11;
        s_axis_tlast  = 2'b00;
        set_src(vecs[0].s0, vecs[0].s1, vecs[0].sh, vecs[0].mu);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_aud_pwm",  AUD_PWM, 0);
        check("rst_aud_sd",   AUD_SD, 0);
        check("rst_sample",   sample_out, 0);
        check("rst_strobe",   sample_strobe, 0);
        check("rst_underrun", underrun_cnt, 0);
        check("rst_misalign", misalign, 0);
        check("rst_tready",   s_axis_tready, 0);

        rst = 1'b0;
        rel_cyc = cyc;
        @(negedge clk);
        check("aud_sd_on", AUD_SD, 1);

        // Table-driven sample path: one vector per tick
        t_prev = rel_cyc;
        for (int i = 0; i < 8; i++) begin
            set_src(vecs[i].s0, vecs[i].s1, vecs[i].sh, vecs[i].mu);
            wait_tick(t_now);
            // Counters are 0 on the release cycle, so the first tick is 2303 edges later.
            check($sformatf("tick_gap_%0d", i), t_now - t_prev, (i == 0) ? 2303 : 2304);
            t_prev = t_now;
            check($sformatf("tready_%0d", i), s_axis_tready, 2'b11);
            @(negedge clk);
            check($sformatf("strobe_%0d", i), sample_strobe, 1);
            check($sformatf("sample_%0d", i), longint'($signed(sample_out)), longint'(vecs[i].exp_s));
            @(negedge clk);
            check($sformatf("strobe_off_%0d", i), sample_strobe, 0);
            repeat (300) @(negedge clk);
            count_high(highs);
            check($sformatf("duty_%0d", i), highs, vecs[i].exp_duty);
        end

        // tlast all-ones is aligned; tlast on src0 only sets the sticky flag
        set_src(16'sd20000, 16'sd10000, 4'd0, 1'b0);
        s_axis_tlast = 2'b11;
        wait_tick(t_now);
        @(negedge clk);
        s_axis_tlast = 2'b00;
        check("misalign_aligned", misalign, 0);
        check("sample_pre_ur", longint'($signed(sample_out)), 30000);
        s_axis_tlast = 2'b01;
        wait_tick(t_now);
        @(negedge clk);
        s_axis_tlast = 2'b00;
        check("misalign_set", misalign, 1);
        wait_tick(t_now);
        @(negedge clk);
        check("misalign_sticky", misalign, 1);
        repeat (300) @(negedge clk);

        // Underrun: src1 drops valid for three ticks
        s_axis_tvalid = 2'b01;
        saw_ready  = 1'b0;
        saw_strobe = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            bit ok;
            ok = 1'b0;
            prev_ur = underrun_cnt;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (s_axis_tready != 2'b00) saw_ready = 1'b1;
                if (sample_strobe) saw_strobe = 1'b1;
                if (underrun_cnt != prev_ur) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                n_tests++;
                n_fail++;
                $display("FAIL underrun_timeout: counter did not move within 3000 cycles (cycle %0d)", cyc);
            end
            check($sformatf("underrun_%0d", r), underrun_cnt, r);
            if (r == 1) begin
                repeat (300) @(negedge clk);
                count_high(highs);
                check("duty_hold_ur", highs, 245);
            end
        end
        check("ur_no_tready", saw_ready, 0);
        check("ur_no_strobe", saw_strobe, 0);
        check("ur_sample_hold", longint'($signed(sample_out)), 30000);

        // Resume normal flow
        s_axis_tvalid = 2'b11;
        set_src(16'sd20000, 16'sd0, 4'd0, 1'b0);
        wait_tick(t_now);
        check("resume_tready", s_axis_tready, 2'b11);
        @(negedge clk);
        check("resume_strobe", sample_strobe, 1);
        check("resume_sample", longint'($signed(sample_out)), 20000);
        check("resume_underrun", underrun_cnt, 3);

        // Reset while AUD_PWM is high with a duty load still pending
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                if (AUD_PWM) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                n_tests++;
                n_fail++;
                $display("FAIL pwm_high_timeout: AUD_PWM never high (cycle %0d)", cyc);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_aud_pwm",  AUD_PWM, 0);
        check("mid_rst_aud_sd",   AUD_SD, 0);
        check("mid_rst_sample",   sample_out, 0);
        check("mid_rst_underrun", underrun_cnt, 0);
        check("mid_rst_misalign", misalign, 0);
        check("mid_rst_tready",   s_axis_tready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        count_high(highs);
        check("post_rst_duty_mid", highs, 128);
        wait_tick(t_now);
        check("post_rst_first_tick", t_now - rel_cyc, 2303);
        @(negedge clk);
        check("post_rst_sample", longint'($signed(sample_out)), 20000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
